// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter slice: shifter mode encodings and requester IDs.
package shift_pkg;
   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_SLL  = 2'b01;
   localparam logic [1:0] MODE_SRL  = 2'b10;
   localparam logic [1:0] MODE_SRA  = 2'b11;

   localparam logic REQ_ALU  = 1'b0;
   localparam logic REQ_ADDR = 1'b1;
endpackage

// File: rtl/shifter.sv
// Combinational 16-bit barrel shifter: PASS, logical left/right, arithmetic right.
module shifter
   import shift_pkg::*;
(
   input  logic [15:0] src,
   input  logic [1:0]  mode,
   input  logic [3:0]  shamt,
   output logic [15:0] result
);

   always_comb begin
      result = src;
      case (mode)
         MODE_SLL: result = src << shamt;
         MODE_SRL: result = src >> shamt;
         MODE_SRA: result = $signed(src) >>> shamt;
         default:  result = src;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between the ALU and address-format
// requesters; the result lands in a single registered slot with a valid/ready handshake.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter bit RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [15:0] req0_src,
   input  logic [1:0]  req0_mode,
   input  logic [3:0]  req0_shamt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [15:0] req1_src,
   input  logic [1:0]  req1_mode,
   input  logic [3:0]  req1_shamt,
   output logic        resp_valid,
   output logic        resp_id,
   output logic [15:0] resp_data,
   input  logic        resp_ready
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_state_t;

   slot_state_t state;
   logic        ptr;
   logic        slot_free;
   logic        grant0;
   logic        grant1;
   logic        accept;
   logic [15:0] sel_src;
   logic [1:0]  sel_mode;
   logic [3:0]  sel_shamt;
   logic [15:0] shift_result;

   // A full slot still counts as free when the consumer drains it this cycle.
   assign slot_free = (state == S_EMPTY) || resp_ready;

   assign grant0 = !rst && slot_free && req0_valid && (!req1_valid || ptr == REQ_ALU);
   assign grant1 = !rst && slot_free && req1_valid && (!req0_valid || ptr == REQ_ADDR);
   assign accept = grant0 || grant1;

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   assign sel_src   = grant1 ? req1_src  : req0_src;
   assign sel_mode  = grant1 ? req1_mode : req0_mode;
   assign sel_shamt = (sel_mode == MODE_PASS) ? 4'd0 : (grant1 ? req1_shamt : req0_shamt);

   shifter u_shifter (
      .src    (sel_src),
      .mode   (sel_mode),
      .shamt  (sel_shamt),
      .result (shift_result)
   );

   assign resp_valid = (state == S_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_EMPTY;
         resp_id   <= REQ_ALU;
         resp_data <= '0;
         ptr       <= RR_INIT;
      end else if (accept) begin
         state     <= S_FULL;
         resp_id   <= grant1;
         resp_data <= shift_result;
         ptr       <= !grant1;
      end else if (resp_ready) begin
         state     <= S_EMPTY;
      end
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 16-bit barrel shifter between two requesters: requester 0 is the ALU execute path, requester 1 is the address/immediate-formatting path.
- Arbitrates round-robin and registers the shifter result into a single output slot.
- Returns the result with a valid/ready handshake and a requester ID.
- Sits in the execute stage ahead of writeback muxing.

Parameters:
- RR_INIT, 0: requester holding priority after reset (0 or 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a shift request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_src  input  16  requester 0 operand
- req0_mode  input  2  requester 0 mode: 01 SLL, 10 SRL, 11 SRA, 00 PASS
- req0_shamt  input  4  requester 0 shift amount, 0..15
- req1_valid, req1_ready, req1_src, req1_mode, req1_shamt: same as requester 0, for requester 1
- resp_valid  output  1  result slot full
- resp_id  output  1  requester that owns resp_data
- resp_data  output  16  registered shift result
- resp_ready  input  1  consumer takes the result this cycle

Behaviour:
- Reset (rst=1 at edge): slot empty, resp_valid=0, resp_id=0, resp_data=0x0000, priority pointer=RR_INIT. A pending result is discarded with no response. During the reset cycle req*_ready=0.
- Slot states: EMPTY and FULL.
  - slot_free = EMPTY, or FULL with resp_ready=1 (pass-through drain).
- Grant, combinational:
  - If slot_free=0, both readies are 0.
  - Otherwise, if exactly one req valid, that requester's ready=1.
  - If both are valid, the requester named by the pointer gets ready=1; the other gets 0.
  - At most one ready high per cycle.
  - ready may depend on both valids. Requesters must not make valid depend on ready.
- Accept = reqN_valid & reqN_ready. At that edge:
  - the selected src/mode/shamt drive the shifter;
  - the result is stored into resp_data;
  - resp_id=N, slot goes FULL;
  - pointer = 1-N.
- Pointer changes only on accept.
- Drain without accept (FULL, resp_ready=1, no grant): slot goes EMPTY next edge. resp_data holds its last value.
- Latency: accept at edge k gives resp_valid=1 in the cycle after edge k. Throughput is 1 result/cycle while resp_ready is held 1.
- Hold rule: while resp_valid=1 and resp_ready=0, resp_data and resp_id are stable and no new accept occurs.
- Mode 00 (PASS): the shifter's shamt input is forced to 0, so the result equals src exactly.
- shamt=0 in any mode gives result = src.
- Arithmetic:
  - SLL zero-fills from the LSB; SRL zero-fills from the MSB; SRA replicates src[15].
  - Bits shifted out are lost; no overflow flag.
- Requester inputs are sampled only on the accepting edge. A request that is not granted may change or drop freely (no fairness obligation for withdrawn requests).
- Fairness: with both requesters continuously valid and resp_ready=1, grants strictly alternate.

Decomposition:
- Shared package shift_pkg holds:
  - mode constants MODE_PASS=2'b00, MODE_SLL=2'b01, MODE_SRL=2'b10, MODE_SRA=2'b11;
  - requester ID constants REQ_ALU=1'b0, REQ_ADDR=1'b1.
- One sub-module: the existing combinational `shifter`, instantiated once inside shift_arbiter, fed by the grant mux. No other hierarchy.

Test Plan:
- Reset with RR_INIT=0, then req0 SLL src=0x0001 shamt=4 with resp_ready=1. Required: req0_ready=1 that cycle; next cycle resp_valid=1, resp_id=0, resp_data=0x0010.
- req1 SRA src=0x8000 shamt=15 gives 0xFFFF. req1 SRL src=0x8000 shamt=15 gives 0x0001. req0 PASS src=0xA5A5 shamt=7 gives 0xA5A5.
- Both valid every cycle after reset (RR_INIT=0), resp_ready=1. Required: grants 0,1,0,1. resp_id sequence 0,1,0,1 on consecutive cycles; no bubbles.
- Backpressure: accept req0 SRL 0xF000 shamt=4, then hold resp_ready=0 for 3 cycles with req1 valid. Required: resp_data=0x0F00 stable, req1_ready=0 throughout. When resp_ready=1, req1_ready=1 in the same cycle, and its result appears the next cycle.
- Reset mid-operation: slot FULL with 0x1234 and resp_ready=0; assert rst for one cycle. Required: resp_valid=0, resp_data=0x0000, pointer=RR_INIT; no stale response after rst deasserts.
- Single requester after a req0 grant: only req1 valid. Required: req1 granted immediately, and the pointer returns to 0 afterward.
